stream_sink_fifo: RTL and testbench



---
 rtl/stream_sink_fifo.sv | 90 +++++++++
 tb/tb_stream_sink_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stream_sink_fifo.sv
// Strobe-in / valid-ready-out FIFO with a sticky overflow flag on words dropped while full.
// Optional drop counter: define STREAM_SINK_FIFO_DROPCNT_EN to add output dropCnt.
module stream_sink_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             validOut,
  input  logic             readyIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [LW-1:0]    level,
  output logic             ovf,
  input  logic             ovfClr
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
  ,
  output logic [15:0]      dropCnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  assign full     = (level == FULL_LEVEL);
  assign validOut = (level != '0);
  assign pop      = validOut & readyIn;
  // A pop frees the slot this same edge, so a full FIFO can still take a word.
  assign push     = enIn & (~full | pop);
  assign drop     = enIn & full & ~pop;
  assign dataOut  = mem[rdPtr];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wrPtr] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Set dominates clear so a drop coinciding with ovfClr is never lost.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     ovf <= 1'b0;
    else if (drop)   ovf <= 1'b1;
    else if (ovfClr) ovf <= 1'b0;
  end

`ifdef STREAM_SINK_FIFO_DROPCNT_EN
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dropCnt <= '0;
    end else if (drop) begin
      dropCnt <= ovfClr ? 16'd1 : satInc16(dropCnt);
    end else if (ovfClr) begin
      dropCnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_sink_fifo.sv
// Scoreboarded bench for stream_sink_fifo: a queue-based reference model predicts
// accepted words, occupancy and overflow; a negedge monitor compares against the DUT.
module tb_stream_sink_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetb;
  logic             enIn;
  logic [WIDTH-1:0] dataIn;
  logic             validOut;
  logic             readyIn;
  logic [WIDTH-1:0] dataOut;
  logic [LW-1:0]    level;
  logic             ovf;
  logic             ovfClr;
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
  logic [15:0]      dropCnt;
`endif

  stream_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetb(resetb),
    .enIn(enIn),
    .dataIn(dataIn),
    .validOut(validOut),
    .readyIn(readyIn),
    .dataOut(dataOut),
    .level(level),
    .ovf(ovf),
    .ovfClr(ovfClr)
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
    ,
    .dropCnt(dropCnt)
`endif
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  // Reference model state: the words held, in order, plus the sticky flag.
  logic [WIDTH-1:0] expQ[$];
  logic             mOvf = 1'b0;
  int               mDrop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor + model: compare what the DUT presents, then advance the model by the
  // inputs that the coming posedge will sample.
  always @(negedge clk) begin
    if (!resetb) begin
      expQ.delete();
      mOvf  = 1'b0;
      mDrop = 0;
      check("rstValid", 64'(validOut), 64'(0));
      check("rstLevel", 64'(level), 64'(0));
    end else begin
      bit isFull, doPop, doPush, doDrop;
      check("validOut", 64'(validOut), 64'(expQ.size() != 0));
      check("level", 64'(level), 64'(expQ.size()));
      check("ovf", 64'(ovf), 64'(mOvf));
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
      check("dropCnt", 64'(dropCnt), 64'(mDrop));
`endif
      if (expQ.size() != 0) check("dataOut", 64'(dataOut), 64'(expQ[0]));
      isFull = (expQ.size() == DEPTH);
      doPop  = (expQ.size() != 0) && readyIn;
      doPush = enIn && (!isFull || doPop);
      doDrop = enIn && isFull && !doPop;
      if (doPop)  void'(expQ.pop_front());
      if (doPush) expQ.push_back(dataIn);
      if (doDrop)      mOvf = 1'b1;
      else if (ovfClr) mOvf = 1'b0;
      if (doDrop)      mDrop = ovfClr ? 1 : (mDrop < 65535 ? mDrop + 1 : 65535);
      else if (ovfClr) mDrop = 0;
    end
  end

  task automatic step(input logic en, input logic [WIDTH-1:0] d, input logic rdy, input logic clr);
    enIn    = en;
    dataIn  = d;
    readyIn = rdy;
    ovfClr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetb  = 1'b0;
    enIn    = 1'b0;
    dataIn  = '0;
    readyIn = 1'b0;
    ovfClr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstDataOut", 64'(dataOut), 64'(0));
    resetb = 1'b1;

    // Single word, no consumer: one cycle to validOut.
    step(1'b1, 32'hA5A50001, 1'b0, 1'b0);
    check("firstValid", 64'(validOut), 64'(1));
    check("firstData", 64'(dataOut), 64'hA5A50001);
    check("firstLevel", 64'(level), 64'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    // Six strobes into a 4-deep FIFO: two drops, then drain 1..4.
    for (int i = 1; i <= 6; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("fillLevel", 64'(level), 64'(4));
    check("fillOvf", 64'(ovf), 64'(1));
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
    check("fillDropCnt", 64'(dropCnt), 64'(2));
`endif
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drainValid", 64'(validOut), 64'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovfCleared", 64'(ovf), 64'(0));

    // Full FIFO accepts a word in the same cycle as a pop.
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 32'd5, 1'b1, 1'b0);
    check("pushPopLevel", 64'(level), 64'(4));
    check("pushPopOvf", 64'(ovf), 64'(0));
    check("pushPopHead", 64'(dataOut), 64'(2));
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Streaming 0..99 with the consumer always ready.
    for (int i = 0; i < 100; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Drop coinciding with ovfClr keeps ovf set; ovfClr alone then clears it.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
    step(1'b1, 32'h1FF, 1'b0, 1'b1);
    check("dropClrOvf", 64'(ovf), 64'(1));
`ifdef STREAM_SINK_FIFO_DROPCNT_EN
    check("dropClrCnt", 64'(dropCnt), 64'(1));
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    check("clrOnlyOvf", 64'(ovf), 64'(0));
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation discards everything.
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(32'h50 + i), 1'b0, 1'b0);
    enIn   = 1'b0;
    #1;
    resetb = 1'b0;
    #1;
    check("asyncRstValid", 64'(validOut), 64'(0));
    check("asyncRstLevel", 64'(level), 64'(0));
    @(posedge clk);
    #1;
    resetb = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    check("postRstData", 64'(dataOut), 64'h77);
    check("postRstLevel", 64'(level), 64'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
